// File: rtl/id_stage_if.sv
// Pipeline-facing signals of the ID stage: IF_ID and hazard/forwarding inputs
// from EX/MEM/WB, plus the fetch-control outputs and the ID_EX register.
interface id_stage_if;
  logic [63:0]  IF_ID;
  logic [1:0]   status;
  logic         EX_MemRead;
  logic         EX_RegWrite;
  logic [4:0]   EX_dst;
  logic         MEM_MemRead;
  logic         MEM_RegWrite;
  logic [4:0]   MEM_dst;
  logic [31:0]  MEM_result;
  logic         WB_write;
  logic [4:0]   WB_dst;
  logic [31:0]  WB_data;
  logic         PC_IF_ID_Write;
  logic [2:0]   select_PC_next;
  logic [31:0]  branch_target;
  logic [31:0]  jump_target;
  logic [31:0]  jr_target;
  logic         exception;
  logic [153:0] ID_EX;

  modport master (
    output IF_ID, status,
    output EX_MemRead, EX_RegWrite, EX_dst,
    output MEM_MemRead, MEM_RegWrite, MEM_dst, MEM_result,
    output WB_write, WB_dst, WB_data,
    input  PC_IF_ID_Write, select_PC_next,
    input  branch_target, jump_target, jr_target,
    input  exception, ID_EX
  );

  modport slave (
    input  IF_ID, status,
    input  EX_MemRead, EX_RegWrite, EX_dst,
    input  MEM_MemRead, MEM_RegWrite, MEM_dst, MEM_result,
    input  WB_write, WB_dst, WB_data,
    output PC_IF_ID_Write, select_PC_next,
    output branch_target, jump_target, jr_target,
    output exception, ID_EX
  );
endinterface

// File: rtl/id_stage.sv
// MIPS ID stage: decode, 32x32 register file with write-through, branch/jump
// resolution with MEM forwarding, hazard stalls and the ID_EX register.
module id_stage (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] IMM_SEXT = 2'd0;
  localparam logic [1:0] IMM_ZEXT = 2'd1;
  localparam logic [1:0] IMM_LUI  = 2'd2;

  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign instr    = bus.IF_ID[31:0];
  assign pc_plus4 = bus.IF_ID[63:32];
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm      = instr[15:0];

  logic       valid;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic [1:0] reg_dst;
  logic [3:0] alu_op;
  logic [1:0] imm_sel;
  logic       use_rs;
  logic       use_rt;
  logic       is_beq;
  logic       is_bne;
  logic       is_j;
  logic       is_jr;

  always_comb begin
    valid      = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 2'b00;
    alu_op     = ALU_ADD;
    imm_sel    = IMM_SEXT;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    is_jr      = 1'b0;
    case (opcode)
      6'h00: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        use_rs    = 1'b1;
        use_rt    = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h26:        alu_op = ALU_XOR;
          6'h27:        alu_op = ALU_NOR;
          6'h2A:        alu_op = ALU_SLT;
          6'h2B:        alu_op = ALU_SLTU;
          6'h00: begin
            alu_op = ALU_SLL;
            use_rs = 1'b0;
          end
          6'h02: begin
            alu_op = ALU_SRL;
            use_rs = 1'b0;
          end
          6'h03: begin
            alu_op = ALU_SRA;
            use_rs = 1'b0;
          end
          6'h08: begin
            reg_write = 1'b0;
            reg_dst   = 2'b00;
            is_jr     = 1'b1;
          end
          6'h09: is_jr = 1'b1;
          default: begin
            valid     = 1'b0;
            reg_write = 1'b0;
            reg_dst   = 2'b00;
            use_rs    = 1'b0;
            use_rt    = 1'b0;
          end
        endcase
        // A flushed IF_ID slot (all zeros) must not look like a register write
        if (instr == 32'h0) reg_write = 1'b0;
      end
      6'h23: begin
        valid      = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        use_rs     = 1'b1;
      end
      6'h2B: begin
        valid     = 1'b1;
        mem_write = 1'b1;
        alu_src   = 1'b1;
        use_rs    = 1'b1;
        use_rt    = 1'b1;
      end
      6'h0F: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_LUI;
        imm_sel   = IMM_LUI;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
        valid     = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        use_rs    = 1'b1;
        case (opcode)
          6'h0A:   alu_op = ALU_SLT;
          6'h0B:   alu_op = ALU_SLTU;
          6'h0C: begin
            alu_op  = ALU_AND;
            imm_sel = IMM_ZEXT;
          end
          6'h0D: begin
            alu_op  = ALU_OR;
            imm_sel = IMM_ZEXT;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      6'h04, 6'h05: begin
        valid  = 1'b1;
        alu_op = ALU_SUB;
        use_rs = 1'b1;
        use_rt = 1'b1;
        is_beq = (opcode == 6'h04);
        is_bne = (opcode == 6'h05);
      end
      6'h02: begin
        valid = 1'b1;
        is_j  = 1'b1;
      end
      6'h03: begin
        valid     = 1'b1;
        is_j      = 1'b1;
        reg_write = 1'b1;
        reg_dst   = 2'b10;
      end
      default: valid = 1'b0;
    endcase
  end

  logic [31:0] rf_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.WB_write && bus.WB_dst != 5'd0) begin
      rf_q[bus.WB_dst] <= bus.WB_data;
    end
  end

  logic [31:0] rs_rf;
  logic [31:0] rt_rf;
  logic [31:0] rs_src;
  logic [31:0] rt_src;

  assign rs_rf = (rs == 5'd0) ? 32'h0 :
                 (bus.WB_write && bus.WB_dst == rs) ? bus.WB_data : rf_q[rs];
  assign rt_rf = (rt == 5'd0) ? 32'h0 :
                 (bus.WB_write && bus.WB_dst == rt) ? bus.WB_data : rf_q[rt];

  // Only a non-load MEM result is ready early enough to feed the comparator
  logic mem_fwd_ok;
  assign mem_fwd_ok = bus.MEM_RegWrite && !bus.MEM_MemRead && bus.MEM_dst != 5'd0;
  assign rs_src = (mem_fwd_ok && bus.MEM_dst == rs) ? bus.MEM_result : rs_rf;
  assign rt_src = (mem_fwd_ok && bus.MEM_dst == rt) ? bus.MEM_result : rt_rf;

  logic [31:0] imm_ext;
  always_comb begin
    imm_ext = {{16{imm[15]}}, imm};
    case (imm_sel)
      IMM_ZEXT: imm_ext = {16'h0, imm};
      IMM_LUI:  imm_ext = {imm, 16'h0};
      default:  imm_ext = {{16{imm[15]}}, imm};
    endcase
  end

  assign bus.branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign bus.jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign bus.jr_target     = rs_src;

  logic br_rs;
  logic br_rt;
  logic ex_hit_rs;
  logic ex_hit_rt;
  logic mem_hit_rs;
  logic mem_hit_rt;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic stall;

  assign br_rs      = is_beq | is_bne | is_jr;
  assign br_rt      = is_beq | is_bne;
  assign ex_hit_rs  = (bus.EX_dst != 5'd0) && (bus.EX_dst == rs);
  assign ex_hit_rt  = (bus.EX_dst != 5'd0) && (bus.EX_dst == rt);
  assign mem_hit_rs = (bus.MEM_dst != 5'd0) && (bus.MEM_dst == rs);
  assign mem_hit_rt = (bus.MEM_dst != 5'd0) && (bus.MEM_dst == rt);
  assign load_use   = bus.EX_MemRead && ((use_rs && ex_hit_rs) || (use_rt && ex_hit_rt));
  assign br_ex      = bus.EX_RegWrite && ((br_rs && ex_hit_rs) || (br_rt && ex_hit_rt));
  assign br_mem     = bus.MEM_MemRead && ((br_rs && mem_hit_rs) || (br_rt && mem_hit_rt));
  assign stall      = valid && (load_use || br_ex || br_mem);

  logic [10:0]  ctrl;
  logic [153:0] id_ex_d;
  logic [153:0] id_ex_q;
  logic [2:0]   sel_pc;
  logic         pc_write;
  logic         undef;

  assign ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op};

  always_comb begin
    id_ex_d  = '0;
    sel_pc   = 3'b000;
    pc_write = 1'b1;
    undef    = 1'b0;
    if (bus.status != 2'b00) begin
      id_ex_d = '0;
    end else if (!valid) begin
      undef = 1'b1;
    end else if (stall) begin
      pc_write = 1'b0;
    end else begin
      id_ex_d = {ctrl, pc_plus4, rs_rf, rt_rf, imm_ext, rs, rt, rd};
      if ((is_beq && rs_src == rt_src) || (is_bne && rs_src != rt_src)) sel_pc = 3'b100;
      else if (is_j)                                                    sel_pc = 3'b010;
      else if (is_jr)                                                   sel_pc = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign bus.ID_EX          = id_ex_q;
  assign bus.select_PC_next = sel_pc;
  assign bus.PC_IF_ID_Write = pc_write;
  assign bus.exception      = undef;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized instruction streams
// compared against a mnemonic-level reference model of decode and hazards.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_rf [32];

  localparam int R_FN [15] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 8, 9};
  localparam int I_OP [13] = '{35, 43, 15, 8, 9, 12, 13, 10, 11, 4, 5, 2, 3};

  task automatic check(input string tag, input logic [153:0] got, input logic [153:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int s, input int t, input int d, input int sh);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int s, input int t, input int im);
    return {6'(op), 5'(s), 5'(t), 16'(im)};
  endfunction

  function automatic string mnem(input logic [31:0] ins);
    string m;
    m = "";
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: m = "add";   6'h21: m = "addu";  6'h22: m = "sub";  6'h23: m = "subu";
        6'h24: m = "and";   6'h25: m = "or";    6'h26: m = "xor";  6'h27: m = "nor";
        6'h2A: m = "slt";   6'h2B: m = "sltu";  6'h00: m = "sll";  6'h02: m = "srl";
        6'h03: m = "sra";   6'h08: m = "jr";    6'h09: m = "jalr";
        default: m = "";
      endcase
      6'h23: m = "lw";    6'h2B: m = "sw";    6'h0F: m = "lui";   6'h08: m = "addi";
      6'h09: m = "addiu"; 6'h0C: m = "andi";  6'h0D: m = "ori";   6'h0A: m = "slti";
      6'h0B: m = "sltiu"; 6'h04: m = "beq";   6'h05: m = "bne";   6'h02: m = "j";
      6'h03: m = "jal";
      default: m = "";
    endcase
    return m;
  endfunction

  function automatic logic [10:0] mk(input bit rw, input bit mr, input bit mw, input bit m2r,
                                     input bit as, input int rd, input int op);
    return {rw, mr, mw, m2r, as, 2'(rd), 4'(op)};
  endfunction

  function automatic logic [10:0] ctrl_of(input string m, input logic [31:0] ins);
    case (m)
      "add", "addu":   return mk(1, 0, 0, 0, 0, 1, 0);
      "sub", "subu":   return mk(1, 0, 0, 0, 0, 1, 1);
      "and":           return mk(1, 0, 0, 0, 0, 1, 2);
      "or":            return mk(1, 0, 0, 0, 0, 1, 3);
      "xor":           return mk(1, 0, 0, 0, 0, 1, 4);
      "nor":           return mk(1, 0, 0, 0, 0, 1, 5);
      "slt":           return mk(1, 0, 0, 0, 0, 1, 6);
      "sltu":          return mk(1, 0, 0, 0, 0, 1, 7);
      "sll":           return mk(ins != 32'h0, 0, 0, 0, 0, 1, 8);
      "srl":           return mk(1, 0, 0, 0, 0, 1, 9);
      "sra":           return mk(1, 0, 0, 0, 0, 1, 10);
      "jr":            return mk(0, 0, 0, 0, 0, 0, 0);
      "jalr":          return mk(1, 0, 0, 0, 0, 1, 0);
      "lw":            return mk(1, 1, 0, 1, 1, 0, 0);
      "sw":            return mk(0, 0, 1, 0, 1, 0, 0);
      "lui":           return mk(1, 0, 0, 0, 1, 0, 11);
      "addi", "addiu": return mk(1, 0, 0, 0, 1, 0, 0);
      "andi":          return mk(1, 0, 0, 0, 1, 0, 2);
      "ori":           return mk(1, 0, 0, 0, 1, 0, 3);
      "slti":          return mk(1, 0, 0, 0, 1, 0, 6);
      "sltiu":         return mk(1, 0, 0, 0, 1, 0, 7);
      "beq", "bne":    return mk(0, 0, 0, 0, 0, 0, 1);
      "jal":           return mk(1, 0, 0, 0, 0, 2, 0);
      default:         return 11'h0;
    endcase
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.WB_write && bus.WB_dst == a) return bus.WB_data;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] src(input logic [4:0] a);
    if (bus.MEM_RegWrite && !bus.MEM_MemRead && bus.MEM_dst != 5'd0 && bus.MEM_dst == a)
      return bus.MEM_result;
    return rf_rd(a);
  endfunction

  task automatic predict(output logic [153:0] idex, output logic [2:0] sel, output logic pcw,
                         output logic exc, output logic [31:0] bt, output logic [31:0] jt,
                         output logic [31:0] jrt);
    logic [31:0] ins, pc4, imx;
    logic [4:0]  rs, rt, rd, ed, md;
    string       m;
    int          off;
    bit          u_rs, u_rt, b_rs, b_rt, stall;
    ins = bus.IF_ID[31:0];
    pc4 = bus.IF_ID[63:32];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    m   = mnem(ins);
    off = ins[15] ? int'(ins[15:0]) - 65536 : int'(ins[15:0]);
    bt  = pc4 + 32'(off * 4);
    jt  = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    jrt = src(rs);
    if (m == "andi" || m == "ori") imx = ins & 32'h0000_FFFF;
    else if (m == "lui")           imx = (ins & 32'h0000_FFFF) << 16;
    else                           imx = 32'(off);
    u_rs = !(m == "j" || m == "jal" || m == "lui" || m == "sll" || m == "srl" || m == "sra");
    u_rt = (ins[31:26] == 6'd0) || m == "sw" || m == "beq" || m == "bne";
    b_rt = (m == "beq" || m == "bne");
    b_rs = b_rt || m == "jr" || m == "jalr";
    ed = bus.EX_dst;
    md = bus.MEM_dst;
    stall = (bus.EX_MemRead && ed != 0 && ((u_rs && ed == rs) || (u_rt && ed == rt)))
         || (bus.EX_RegWrite && ed != 0 && ((b_rs && ed == rs) || (b_rt && ed == rt)))
         || (bus.MEM_MemRead && md != 0 && ((b_rs && md == rs) || (b_rt && md == rt)));
    idex = '0;
    sel  = 3'b000;
    pcw  = 1'b1;
    exc  = 1'b0;
    if (bus.status != 2'b00) begin
      idex = '0;
    end else if (m == "") begin
      exc = 1'b1;
    end else if (stall) begin
      pcw = 1'b0;
    end else begin
      idex = {ctrl_of(m, ins), pc4, rf_rd(rs), rf_rd(rt), imx, rs, rt, rd};
      if ((m == "beq" && src(rs) == src(rt)) || (m == "bne" && src(rs) != src(rt))) sel = 3'b100;
      else if (m == "j" || m == "jal")   sel = 3'b010;
      else if (m == "jr" || m == "jalr") sel = 3'b001;
    end
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle(input string tag);
    logic [153:0] e_idex;
    logic [2:0]   e_sel;
    logic         e_pcw, e_exc;
    logic [31:0]  e_bt, e_jt, e_jrt;
    #1;
    predict(e_idex, e_sel, e_pcw, e_exc, e_bt, e_jt, e_jrt);
    check({tag, " sel"}, bus.select_PC_next, e_sel);
    check({tag, " pcw"}, bus.PC_IF_ID_Write, e_pcw);
    check({tag, " exc"}, bus.exception, e_exc);
    check({tag, " btgt"}, bus.branch_target, e_bt);
    check({tag, " jtgt"}, bus.jump_target, e_jt);
    check({tag, " jrtgt"}, bus.jr_target, e_jrt);
    @(posedge clk);
    if (rst_n && bus.WB_write && bus.WB_dst != 5'd0) m_rf[bus.WB_dst] = bus.WB_data;
    #1;
    check({tag, " id_ex"}, bus.ID_EX, e_idex);
    @(negedge clk);
  endtask

  task automatic clear_side();
    bus.status       = 2'b00;
    bus.EX_MemRead   = 1'b0;
    bus.EX_RegWrite  = 1'b0;
    bus.EX_dst       = 5'd0;
    bus.MEM_MemRead  = 1'b0;
    bus.MEM_RegWrite = 1'b0;
    bus.MEM_dst      = 5'd0;
    bus.MEM_result   = 32'h0;
    bus.WB_write     = 1'b0;
    bus.WB_dst       = 5'd0;
    bus.WB_data      = 32'h0;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 3)
      return enc_r(R_FN[$urandom_range(0, 14)], $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 31));
    if (k <= 7)
      return enc_i(I_OP[$urandom_range(0, 12)], $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 65535));
    if (k == 8) return 32'h0;
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0;
    clear_side();
    bus.IF_ID = 64'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    repeat (2) @(negedge clk);
    check("reset id_ex", bus.ID_EX, 154'h0);
    rst_n = 1'b1;

    // Write-through: same-cycle WB to $5 is visible to add $6,$5,$0
    bus.WB_write = 1'b1; bus.WB_dst = 5'd5; bus.WB_data = 32'h1234_5678;
    bus.IF_ID = {32'h0000_1004, enc_r(32, 5, 0, 6, 0)};
    cycle("rf_wt");
    check("rf_wt rs_data", bus.ID_EX[110:79], 32'h1234_5678);

    // Writes to $0 are dropped
    bus.WB_dst = 5'd0; bus.WB_data = 32'hFFFF_FFFF;
    bus.IF_ID = {32'h0000_1008, enc_r(32, 0, 0, 7, 0)};
    cycle("r0_wr");
    clear_side();
    cycle("r0_rd");
    check("r0 rs_data", bus.ID_EX[110:79], 32'h0);

    // Load-use stall for one cycle, then issue
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_dst = 5'd8;
    bus.IF_ID = {32'h0000_100C, enc_r(32, 8, 1, 9, 0)};
    #1 check("lu pcw", bus.PC_IF_ID_Write, 1'b0);
    cycle("lu_stall");
    check("lu bubble", bus.ID_EX, 154'h0);
    clear_side();
    cycle("lu_issue");
    check("lu aluop", bus.ID_EX[146:143], 4'd0);
    check("lu regdst", bus.ID_EX[148:147], 2'b01);

    // Branch taken through MEM forwarding
    bus.WB_write = 1'b1; bus.WB_dst = 5'd4; bus.WB_data = 32'h0000_CAFE;
    bus.IF_ID = 64'h0;
    cycle("ld_r4");
    clear_side();
    bus.MEM_RegWrite = 1'b1; bus.MEM_dst = 5'd3; bus.MEM_result = 32'h0000_CAFE;
    bus.IF_ID = {32'h8000_0010, enc_i(4, 3, 4, 16'hFFFE)};
    #1 check("bfwd sel", bus.select_PC_next, 3'b100);
    check("bfwd target", bus.branch_target, 32'h8000_0008);
    cycle("bfwd");

    // bne behind a load: stall in EX, stall in MEM, resolve on write-through
    clear_side();
    bus.IF_ID = {32'h8000_0020, enc_i(5, 3, 4, 4)};
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_dst = 5'd3;
    #1 check("bld s1 pcw", bus.PC_IF_ID_Write, 1'b0);
    cycle("bld_s1");
    clear_side();
    bus.MEM_MemRead = 1'b1; bus.MEM_RegWrite = 1'b1; bus.MEM_dst = 5'd3; bus.MEM_result = 32'h40;
    #1 check("bld s2 pcw", bus.PC_IF_ID_Write, 1'b0);
    cycle("bld_s2");
    clear_side();
    bus.WB_write = 1'b1; bus.WB_dst = 5'd3; bus.WB_data = 32'h0000_1111;
    #1 check("bld res pcw", bus.PC_IF_ID_Write, 1'b1);
    check("bld res sel", bus.select_PC_next, 3'b100);
    cycle("bld_res");

    // j and jr
    clear_side();
    bus.IF_ID = {32'h8000_0004, enc_i(2, 0, 0, 16'h0040)};
    #1 check("j sel", bus.select_PC_next, 3'b010);
    check("j target", bus.jump_target, 32'h8000_0100);
    cycle("j");
    bus.WB_write = 1'b1; bus.WB_dst = 5'd31; bus.WB_data = 32'h0040_0020;
    bus.IF_ID = 64'h0;
    cycle("ld_r31");
    clear_side();
    bus.IF_ID = {32'h8000_0030, enc_r(8, 31, 0, 0, 0)};
    #1 check("jr sel", bus.select_PC_next, 3'b001);
    check("jr target", bus.jr_target, 32'h0040_0020);
    cycle("jr");

    // Undefined opcode, then status redirect, then flushed slot
    bus.IF_ID = {32'h8000_0040, 6'h3F, 26'h0};
    #1 check("undef exc", bus.exception, 1'b1);
    cycle("undef");
    check("undef bubble", bus.ID_EX, 154'h0);
    bus.status = 2'b10;
    bus.IF_ID = {32'h8000_0044, enc_r(32, 5, 4, 6, 0)};
    #1 check("status sel", bus.select_PC_next, 3'b000);
    cycle("status");
    check("status bubble", bus.ID_EX, 154'h0);
    clear_side();
    bus.IF_ID = 64'h0;
    cycle("nop");
    check("nop regwrite", bus.ID_EX[153], 1'b0);

    // Reset in the middle of a stall
    bus.IF_ID = {32'h8000_0050, enc_r(32, 5, 0, 6, 0)};
    cycle("pre_rst");
    bus.EX_MemRead = 1'b1; bus.EX_dst = 5'd5;
    #1 check("rst stall pcw", bus.PC_IF_ID_Write, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("rst async id_ex", bus.ID_EX, 154'h0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_side();
    cycle("post_rst");
    check("post_rst rs_data", bus.ID_EX[110:79], 32'h0);

    for (int n = 0; n < 3000; n++) begin
      bus.IF_ID        = {$urandom & 32'hFFFF_FFFC, rand_instr()};
      bus.status       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.EX_MemRead   = ($urandom_range(0, 3) == 0);
      bus.EX_RegWrite  = ($urandom_range(0, 1) == 0);
      bus.EX_dst       = 5'($urandom_range(0, 7));
      bus.MEM_MemRead  = ($urandom_range(0, 3) == 0);
      bus.MEM_RegWrite = ($urandom_range(0, 1) == 0);
      bus.MEM_dst      = 5'($urandom_range(0, 7));
      bus.MEM_result   = ($urandom_range(0, 1) == 0) ? m_rf[$urandom_range(0, 7)] : $urandom;
      bus.WB_write     = ($urandom_range(0, 1) == 0);
      bus.WB_dst       = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      bus.WB_data      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
